// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types for the iterative magnitude comparator: FSM states, cascade state, digit count helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic e;
        logic l;
        logic g;
    } cmp_eg_t;

    localparam cmp_eg_t EG_CLEAR_C = '{e: 1'b0, l: 1'b0, g: 1'b0};
    localparam cmp_eg_t EG_START_C = '{e: 1'b1, l: 1'b0, g: 1'b0};

    function automatic int ndig_f(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit_slice.sv
// Combinational DIGIT-bit comparator built as an MSB-first chain of single-bit E/L/G stages.
module cmp_digit_slice
    import cmp_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    input  cmp_eg_t          eg_in,
    output cmp_eg_t          eg_out
);

    // Once a difference has been seen (e=0) the stage passes the decision through unchanged.
    function automatic cmp_eg_t bit_stage(input logic a_bit, input logic b_bit, input cmp_eg_t eg);
        cmp_eg_t res;
        if (!eg.e) begin
            res = eg;
        end else if (a_bit == b_bit) begin
            res = EG_START_C;
        end else if (a_bit) begin
            res = '{e: 1'b0, l: 1'b0, g: 1'b1};
        end else begin
            res = '{e: 1'b0, l: 1'b1, g: 1'b0};
        end
        return res;
    endfunction

    cmp_eg_t chain_s;

    // Ripple the cascade state from the digit MSB down to its LSB.
    always_comb begin
        chain_s = eg_in;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            chain_s = bit_stage(a_dig[i], b_dig[i], chain_s);
        end
    end

    assign eg_out = chain_s;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Iterative MSB-first magnitude comparator, DIGIT bits per clock, valid/ready on both sides.
// Define SEQ_CMP_SIGNED_EN for two's-complement operands (offset-binary on the top bit).
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              eq,
    output logic                              lt,
    output logic                              gt,
    output logic                              busy,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]  ndig
);

    localparam int NDIG = ndig_f(WIDTH, DIGIT);
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST_C = CW'(NDIG - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    cmp_state_t        state_r;
    cmp_state_t        state_s;
    logic [WIDTH-1:0]  a_sh_r;
    logic [WIDTH-1:0]  b_sh_r;
    logic [WIDTH-1:0]  a_load_s;
    logic [WIDTH-1:0]  b_load_s;
    cmp_eg_t           eg_r;
    cmp_eg_t           eg_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     ndig_r;
    logic              eq_r;
    logic              lt_r;
    logic              gt_r;
    logic              finish_s;

`ifdef SEQ_CMP_SIGNED_EN
    // Flipping the sign bit maps two's complement onto unsigned order; only digit 0 sees it.
    always_comb begin
        a_load_s            = a;
        b_load_s            = b;
        a_load_s[WIDTH-1]   = ~a[WIDTH-1];
        b_load_s[WIDTH-1]   = ~b[WIDTH-1];
    end
`else
    assign a_load_s = a;
    assign b_load_s = b;
`endif

    cmp_digit_slice #(.DIGIT(DIGIT)) u_slice (
        .a_dig  (a_sh_r[WIDTH-1 -: DIGIT]),
        .b_dig  (b_sh_r[WIDTH-1 -: DIGIT]),
        .eg_in  (eg_r),
        .eg_out (eg_s)
    );

    // The last digit always ends the run; early exit also ends it on the first difference.
    always_comb begin
        finish_s = 1'b0;
        if ((cnt_r == LAST_C) || ((EARLY_EXIT == 1) && !eg_s.e)) begin
            finish_s = 1'b1;
        end else begin
            finish_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (in_valid)  state_s = RUN;  else state_s = IDLE;
            RUN:     if (finish_s)  state_s = DONE; else state_s = RUN;
            DONE:    if (out_ready) state_s = IDLE; else state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // Handshake and status decode from the registered state.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = !rst;
            RUN:     busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Operand shift registers, cascade state, digit counter and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r <= '0;
            b_sh_r <= '0;
            eg_r   <= EG_CLEAR_C;
            cnt_r  <= '0;
            ndig_r <= '0;
            eq_r   <= 1'b0;
            lt_r   <= 1'b0;
            gt_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r <= a_load_s;
                        b_sh_r <= b_load_s;
                        eg_r   <= EG_START_C;
                        cnt_r  <= '0;
                    end
                end
                RUN: begin
                    eg_r   <= eg_s;
                    a_sh_r <= a_sh_r << DIGIT;
                    b_sh_r <= b_sh_r << DIGIT;
                    cnt_r  <= cnt_r + ONE_C;
                    if (finish_s) begin
                        eq_r   <= eg_s.e;
                        lt_r   <= eg_s.l;
                        gt_r   <= eg_s.g;
                        ndig_r <= cnt_r + ONE_C;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        eq_r   <= 1'b0;
                        lt_r   <= 1'b0;
                        gt_r   <= 1'b0;
                        ndig_r <= '0;
                    end
                end
                default: begin
                    eg_r <= EG_CLEAR_C;
                end
            endcase
        end
    end

    assign eq   = eq_r;
    assign lt   = lt_r;
    assign gt   = gt_r;
    assign ndig = ndig_r;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed, table-driven bench: default build, a constant-latency build and a single-digit build.
module tb_seq_magnitude_comparator;

`ifdef SEQ_CMP_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  res_u;
        int          nd_u;
        logic [2:0]  res_s;
        int          nd_s;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a16 = 16'h0000;
    logic [15:0] b16 = 16'h0000;
    logic [7:0]  a8  = 8'h00;
    logic [7:0]  b8  = 8'h00;
    logic iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
    logic or0 = 1'b1, or1 = 1'b1, or2 = 1'b1;
    logic ir0, ir1, ir2, ov0, ov1, ov2;
    logic eq0, eq1, eq2, lt0, lt1, lt2, gt0, gt1, gt2, bz0, bz1, bz2;
    logic [2:0] nd0, nd1;
    logic [0:0] nd2;

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a16), .b(b16),
        .out_valid(ov0), .out_ready(or0), .eq(eq0), .lt(lt0), .gt(gt0), .busy(bz0), .ndig(nd0));

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) dut_ne (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a16), .b(b16),
        .out_valid(ov1), .out_ready(or1), .eq(eq1), .lt(lt1), .gt(gt1), .busy(bz1), .ndig(nd1));

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(8), .EARLY_EXIT(1)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a8), .b(b8),
        .out_valid(ov2), .out_ready(or2), .eq(eq2), .lt(lt2), .gt(gt2), .busy(bz2), .ndig(nd2));

    int sel = 0;
    logic m_ir, m_ov, m_bz;
    logic [2:0] m_res;
    logic [31:0] m_nd;

    always_comb begin
        case (sel)
            1:       begin m_ir = ir1; m_ov = ov1; m_bz = bz1; m_res = {eq1, lt1, gt1}; m_nd = 32'(nd1); end
            2:       begin m_ir = ir2; m_ov = ov2; m_bz = bz2; m_res = {eq2, lt2, gt2}; m_nd = 32'(nd2); end
            default: begin m_ir = ir0; m_ov = ov0; m_bz = bz0; m_res = {eq0, lt0, gt0}; m_nd = 32'(nd0); end
        endcase
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s (dut %0d): got 0x%0h, expected 0x%0h at %0t", name, sel, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!m_ov && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One transaction with out_ready held high; checks latency, result, ndig and the one-cycle pulse.
    task automatic do_cmp(input int s, input logic [15:0] av, input logic [15:0] bv,
                          input logic [2:0] res, input int nd);
        int lat;
        sel = s;
        @(negedge clk);
        chk("in_ready_idle", 32'(m_ir), 32'd1);
        case (s)
            1:       begin a16 = av; b16 = bv; iv1 = 1'b1; end
            2:       begin a8 = av[7:0]; b8 = bv[7:0]; iv2 = 1'b1; end
            default: begin a16 = av; b16 = bv; iv0 = 1'b1; end
        endcase
        @(negedge clk);
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        a16 = ~a16; b16 = 16'h0000; a8 = ~a8; b8 = 8'h00;
        wait_valid(lat);
        chk("latency", 32'(lat), 32'(nd + 1));
        chk("result", 32'(m_res), 32'(res));
        chk("ndig", m_nd, 32'(nd));
        chk("in_ready_done", 32'(m_ir), 32'd0);
        @(negedge clk);
        chk("pulse_drop", {31'd0, m_ov}, 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        int lat;
        vecs[0] = '{16'h1234, 16'h1234, R_EQ, 4, R_EQ, 4};
        vecs[1] = '{16'h9000, 16'h1FFF, R_GT, 1, R_LT, 1};
        vecs[2] = '{16'h00A3, 16'h00A4, R_LT, 4, R_LT, 4};
        vecs[3] = '{16'hFFFF, 16'h0001, R_GT, 1, R_LT, 1};
        vecs[4] = '{16'h0005, 16'h0003, R_GT, 4, R_GT, 4};
        vecs[5] = '{16'h1200, 16'h1300, R_LT, 2, R_LT, 2};
        vecs[6] = '{16'hABCD, 16'hAB0D, R_GT, 3, R_GT, 3};
        vecs[7] = '{16'h0000, 16'h0000, R_EQ, 4, R_EQ, 4};
        vecs[8] = '{16'h8000, 16'h7FFF, R_GT, 1, R_LT, 1};

        // Reset with in_valid asserted: must stay idle with all outputs cleared.
        rst = 1'b1;
        iv0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(ir0), 32'd0);
        chk("rst_outputs", {26'd0, ov0, eq0, lt0, gt0, bz0, 1'b0}, 32'd0);
        chk("rst_ndig", 32'(nd0), 32'd0);
        iv0 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, ir0, bz0}, 32'd2);

        for (int i = 0; i < 9; i++) begin
            do_cmp(0, vecs[i].a, vecs[i].b,
                   SGN ? vecs[i].res_s : vecs[i].res_u,
                   SGN ? vecs[i].nd_s  : vecs[i].nd_u);
        end

        // Constant-latency build never exits early.
        do_cmp(1, 16'h9000, 16'h1FFF, SGN ? R_LT : R_GT, 4);
        do_cmp(1, 16'h1200, 16'h1300, R_LT, 4);

        // Single-digit build, back to back.
        do_cmp(2, 16'h007F, 16'h0080, SGN ? R_GT : R_LT, 1);
        do_cmp(2, 16'h0042, 16'h0042, R_EQ, 1);

        // Result held while out_ready is low.
        sel = 0;
        or0 = 1'b0;
        @(negedge clk);
        a16 = 16'h00A3; b16 = 16'h00A4; iv0 = 1'b1;
        @(negedge clk);
        a16 = 16'h0000;
        wait_valid(lat);
        chk("hold_latency", 32'(lat), 32'd5);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_stable", {24'd0, m_ov, m_ir, m_bz, m_res, m_nd[1:0]}, {24'd0, 1'b1, 1'b0, 1'b0, R_LT, 2'd0});
            chk("hold_ndig", m_nd, 32'd4);
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        @(negedge clk);
        chk("hold_release", {30'd0, m_ov, m_ir}, 32'd1);

        // Reset in the middle of a full-length compare.
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h1234; iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
        chk("mid_busy", 32'(m_bz), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(m_ir), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_state", {28'd0, m_ov, m_bz, m_ir, 1'b0}, 32'd2);
        chk("mid_rst_result", 32'(m_res), 32'd0);
        do_cmp(0, 16'h0005, 16'h0003, R_GT, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
